// File: rtl/sys_array_lock_arbiter.sv
// ---------------------------------------------------------------------------
// sys_array_lock_arbiter
//
// Shares the systolic array between two hardware threads. There are two
// independent lock channels:
//   COMP : operand addresses A, D and C
//   LOAD : operand address B
// Each channel grants one thread at a time using round-robin. At the grant
// edge it latches that thread's addresses and pulses start to the array
// controller. It holds the lock until the array reports done and the owner
// drops its request.
//
// Optional feature: define SYS_ARRAY_ARB_WATCHDOG_EN to add a BUSY
// watchdog. It forces completion after TIMEOUT_CYCLES cycles without done
// and sets a sticky timeout flag. Without the macro the timeout outputs
// are tied to 0 and BUSY waits indefinitely.
//
// Ports:
//   clock                         rising-edge clock
//   reset                         asynchronous, active-low reset
//   comp_lock_req/comp_lock_res   per-thread COMP request / one-hot grant
//   A_addr, D_addr, C_addr        per-thread COMP operand addresses
//   comp_start, comp_finished     start pulse to array / completion to owner
//   comp_A_addr/_D_addr/_C_addr   latched COMP addresses
//   comp_done                     completion pulse from array controller
//   load_lock_req/load_lock_res   per-thread LOAD request / one-hot grant
//   B_addr                        per-thread LOAD address
//   load_start, load_finished     start pulse to array / completion to owner
//   load_B_addr                   latched LOAD address
//   load_done                     completion pulse from array controller
//   comp_timeout, load_timeout    sticky watchdog flags
// ---------------------------------------------------------------------------
module sys_array_lock_arbiter #(
    parameter int BITWIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               comp_lock_req,
    output logic [1:0]               comp_lock_res,
    input  logic [1:0][BITWIDTH-1:0] A_addr,
    input  logic [1:0][BITWIDTH-1:0] D_addr,
    input  logic [1:0][BITWIDTH-1:0] C_addr,
    output logic                     comp_finished,
    input  logic [1:0]               load_lock_req,
    output logic [1:0]               load_lock_res,
    input  logic [1:0][BITWIDTH-1:0] B_addr,
    output logic                     load_finished,
    output logic                     comp_start,
    output logic                     load_start,
    output logic [BITWIDTH-1:0]      comp_A_addr,
    output logic [BITWIDTH-1:0]      comp_D_addr,
    output logic [BITWIDTH-1:0]      comp_C_addr,
    output logic [BITWIDTH-1:0]      load_B_addr,
    input  logic                     comp_done,
    input  logic                     load_done,
    output logic                     comp_timeout,
    output logic                     load_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

`ifdef SYS_ARRAY_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`endif

    // Channel 0 is COMP, channel 1 is LOAD.
    logic [1:0][1:0] w_req;
    logic [1:0]      w_done;
    logic [1:0][1:0] w_lock_res;
    logic [1:0]      w_start;
    logic [1:0]      w_finished;
    logic [1:0]      w_grant;
    logic [1:0]      w_winner;
    logic [1:0]      w_timeout;

    assign w_req[0] = comp_lock_req;
    assign w_req[1] = load_lock_req;
    assign w_done   = {load_done, comp_done};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        state_t     r_state, w_state_next;
        logic       r_owner, w_owner_next;
        logic       r_last_owner, w_last_owner_next;
        logic [1:0] r_lock_res, w_lock_res_next;
        logic       r_start;
        logic       r_finished, w_finished_next;
        logic       w_win;
        logic       w_grant_now;
        logic       w_expire;

        // On contention the thread that did not own the channel last wins;
        // with a single requester, req[1] alone names the winner.
        assign w_win       = (w_req[g] == 2'b11) ? ~r_last_owner : w_req[g][1];
        assign w_grant_now = (r_state == ST_IDLE) && (|w_req[g]);

        always_comb begin
            w_state_next      = r_state;
            w_owner_next      = r_owner;
            w_last_owner_next = r_last_owner;
            w_lock_res_next   = r_lock_res;
            w_finished_next   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_now) begin
                        w_owner_next    = w_win;
                        w_lock_res_next = w_win ? 2'b10 : 2'b01;
                        w_state_next    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A dropped request is ignored here: there is no abort.
                    if (w_done[g] || w_expire) begin
                        w_finished_next = 1'b1;
                        w_state_next    = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_req[g][r_owner]) begin
                        w_lock_res_next   = 2'b00;
                        w_last_owner_next = r_owner;
                        w_state_next      = ST_IDLE;
                    end
                end
                default: begin
                    w_lock_res_next = 2'b00;
                    w_state_next    = ST_IDLE;
                end
            endcase
        end

        // last_owner resets to 1 so thread 0 wins the first contention.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_state      <= ST_IDLE;
                r_owner      <= 1'b0;
                r_last_owner <= 1'b1;
                r_lock_res   <= 2'b00;
                r_start      <= 1'b0;
                r_finished   <= 1'b0;
            end else begin
                r_state      <= w_state_next;
                r_owner      <= w_owner_next;
                r_last_owner <= w_last_owner_next;
                r_lock_res   <= w_lock_res_next;
                r_start      <= w_grant_now;
                r_finished   <= w_finished_next;
            end
        end

`ifdef SYS_ARRAY_ARB_WATCHDOG_EN
        logic [CW-1:0] r_count, w_count_next;
        logic          r_timeout;

        // The count is the number of BUSY cycles completed so far. Expiry
        // happens on the edge where it reaches TIMEOUT_CYCLES.
        always_comb begin
            w_count_next = '0;
            w_expire     = 1'b0;
            if (r_state == ST_BUSY) begin
                w_count_next = r_count + CW'(1);
                w_expire     = (w_count_next == CW'(TIMEOUT_CYCLES));
            end
        end

        // A done on the expiry edge wins, so the flag stays clear.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_count   <= '0;
                r_timeout <= 1'b0;
            end else begin
                r_count <= w_count_next;
                if (w_expire && !w_done[g]) begin
                    r_timeout <= 1'b1;
                end
            end
        end

        assign w_timeout[g] = r_timeout;
`else
        assign w_expire     = 1'b0;
        assign w_timeout[g] = 1'b0;
`endif

        assign w_lock_res[g] = r_lock_res;
        assign w_start[g]    = r_start;
        assign w_finished[g] = r_finished;
        assign w_grant[g]    = w_grant_now;
        assign w_winner[g]   = w_win;
    end

    logic [BITWIDTH-1:0] r_comp_A_addr, r_comp_D_addr, r_comp_C_addr;
    logic [BITWIDTH-1:0] r_load_B_addr;

    // Addresses are captured only on the grant edge. They then hold until
    // the next grant on the same channel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_comp_A_addr <= '0;
            r_comp_D_addr <= '0;
            r_comp_C_addr <= '0;
            r_load_B_addr <= '0;
        end else begin
            if (w_grant[0]) begin
                r_comp_A_addr <= A_addr[w_winner[0]];
                r_comp_D_addr <= D_addr[w_winner[0]];
                r_comp_C_addr <= C_addr[w_winner[0]];
            end
            if (w_grant[1]) begin
                r_load_B_addr <= B_addr[w_winner[1]];
            end
        end
    end

    assign comp_lock_res = w_lock_res[0];
    assign load_lock_res = w_lock_res[1];
    assign comp_start    = w_start[0];
    assign load_start    = w_start[1];
    assign comp_finished = w_finished[0];
    assign load_finished = w_finished[1];
    assign comp_timeout  = w_timeout[0];
    assign load_timeout  = w_timeout[1];
    assign comp_A_addr   = r_comp_A_addr;
    assign comp_D_addr   = r_comp_D_addr;
    assign comp_C_addr   = r_comp_C_addr;
    assign load_B_addr   = r_load_B_addr;

endmodule

// File: tb/tb_sys_array_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sys_array_lock_arbiter
//
// Scoreboard bench for sys_array_lock_arbiter. Stimulus pushes expected
// start/finished events (with the cycle they must appear in) into
// per-channel queues. A monitor pops and compares an entry whenever the
// DUT shows a start or finished pulse. Compile with
// SYS_ARRAY_ARB_WATCHDOG_EN to run the watchdog scenarios instead of the
// no-watchdog scenario.
// ---------------------------------------------------------------------------
module tb_sys_array_lock_arbiter;
    localparam int BW = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic [1:0]          comp_lock_req, comp_lock_res;
    logic [1:0][BW-1:0]  A_addr, D_addr, C_addr, B_addr;
    logic                comp_finished, load_finished;
    logic [1:0]          load_lock_req, load_lock_res;
    logic                comp_start, load_start;
    logic [BW-1:0]       comp_A_addr, comp_D_addr, comp_C_addr, load_B_addr;
    logic                comp_done, load_done;
    logic                comp_timeout, load_timeout;

    typedef struct {
        bit            isStart;
        logic [1:0]    lock;
        logic [BW-1:0] a0;
        logic [BW-1:0] a1;
        logic [BW-1:0] a2;
        int            cyc;
    } exp_t;

    exp_t compQ[$];
    exp_t loadQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    sys_array_lock_arbiter #(
        .BITWIDTH      (BW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .comp_lock_req(comp_lock_req),
        .comp_lock_res(comp_lock_res),
        .A_addr       (A_addr),
        .D_addr       (D_addr),
        .C_addr       (C_addr),
        .comp_finished(comp_finished),
        .load_lock_req(load_lock_req),
        .load_lock_res(load_lock_res),
        .B_addr       (B_addr),
        .load_finished(load_finished),
        .comp_start   (comp_start),
        .load_start   (load_start),
        .comp_A_addr  (comp_A_addr),
        .comp_D_addr  (comp_D_addr),
        .comp_C_addr  (comp_C_addr),
        .load_B_addr  (load_B_addr),
        .comp_done    (comp_done),
        .load_done    (load_done),
        .comp_timeout (comp_timeout),
        .load_timeout (load_timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compareEvent(input string ch, input exp_t e, input logic isStart,
                                input logic [1:0] lock, input logic [BW-1:0] a0,
                                input logic [BW-1:0] a1, input logic [BW-1:0] a2);
        checkOutput({ch, "Kind"}, {31'd0, isStart}, {31'd0, e.isStart});
        checkOutput({ch, "Cycle"}, cyc, e.cyc);
        checkOutput({ch, "Lock"}, {30'd0, lock}, {30'd0, e.lock});
        if (e.isStart) begin
            checkOutput({ch, "Addr0"}, a0, e.a0);
            checkOutput({ch, "Addr1"}, a1, e.a1);
            checkOutput({ch, "Addr2"}, a2, e.a2);
        end
    endtask

    // Delta is the number of negedges from now at which the event appears.
    task automatic expectComp(input bit isStart, input logic [1:0] lock, input logic [BW-1:0] a,
                              input logic [BW-1:0] d, input logic [BW-1:0] c, input int delta);
        exp_t e;
        e.isStart = isStart; e.lock = lock; e.a0 = a; e.a1 = d; e.a2 = c; e.cyc = cyc + delta;
        compQ.push_back(e);
    endtask

    task automatic expectLoad(input bit isStart, input logic [1:0] lock, input logic [BW-1:0] b,
                              input int delta);
        exp_t e;
        e.isStart = isStart; e.lock = lock; e.a0 = b; e.a1 = '0; e.a2 = '0; e.cyc = cyc + delta;
        loadQ.push_back(e);
    endtask

    // Drive one cycle of inputs at a negedge; done inputs are single-cycle pulses.
    task automatic applyStimulus(input logic [1:0] cReq, input logic [1:0] lReq,
                                 input logic cDone, input logic lDone);
        comp_lock_req = cReq;
        load_lock_req = lReq;
        comp_done     = cDone;
        load_done     = lDone;
        @(negedge clock);
        comp_done = 1'b0;
        load_done = 1'b0;
    endtask

    task automatic resetDut();
        reset         = 1'b0;
        comp_lock_req = 2'b00;
        load_lock_req = 2'b00;
        comp_done     = 1'b0;
        load_done     = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: every start/finished pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (comp_start || comp_finished) begin
                if (compQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL compUnexpected: start=%0b finished=%0b at cycle %0d, expected no event",
                             comp_start, comp_finished, cyc);
                end else begin
                    compareEvent("comp", compQ.pop_front(), comp_start, comp_lock_res,
                                 comp_A_addr, comp_D_addr, comp_C_addr);
                end
            end
            if (load_start || load_finished) begin
                if (loadQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL loadUnexpected: start=%0b finished=%0b at cycle %0d, expected no event",
                             load_start, load_finished, cyc);
                end else begin
                    compareEvent("load", loadQ.pop_front(), load_start, load_lock_res,
                                 load_B_addr, '0, '0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout: simulation still running, expected to finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset         = 1'b0;
        comp_lock_req = 2'b00;
        load_lock_req = 2'b00;
        comp_done     = 1'b0;
        load_done     = 1'b0;
        A_addr[0] = 32'h10; D_addr[0] = 32'h20; C_addr[0] = 32'h30; B_addr[0] = 32'h40;
        A_addr[1] = 32'h11; D_addr[1] = 32'h21; C_addr[1] = 32'h31; B_addr[1] = 32'h41;
        repeat (2) @(negedge clock);
        checkOutput("rstCompLock", {30'd0, comp_lock_res}, 0);
        checkOutput("rstLoadLock", {30'd0, load_lock_res}, 0);
        checkOutput("rstCompStart", {31'd0, comp_start}, 0);
        checkOutput("rstCompAddrA", comp_A_addr, 0);
        checkOutput("rstLoadAddrB", load_B_addr, 0);
        checkOutput("rstCompTimeout", {31'd0, comp_timeout}, 0);
        checkOutput("rstLoadTimeout", {31'd0, load_timeout}, 0);
        reset = 1'b1;
        @(negedge clock);

        $display("[TB] single request");
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        applyStimulus(2'b01, 2'b00, 0, 0);
        applyStimulus(2'b01, 2'b00, 0, 0);
        checkOutput("singleStartPulse", {31'd0, comp_start}, 0);
        checkOutput("singleHold", {30'd0, comp_lock_res}, 2'b01);
        checkOutput("singleAddrA", comp_A_addr, 32'h10);
        expectComp(0, 2'b01, 0, 0, 0, 1);
        applyStimulus(2'b01, 2'b00, 1, 0);
        applyStimulus(2'b01, 2'b00, 1, 0);
        checkOutput("releaseHold", {30'd0, comp_lock_res}, 2'b01);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("releaseDrop", {30'd0, comp_lock_res}, 2'b00);

        $display("[TB] contention after reset");
        resetDut();
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        applyStimulus(2'b11, 2'b00, 0, 0);
        expectComp(0, 2'b01, 0, 0, 0, 1);
        applyStimulus(2'b11, 2'b00, 1, 0);
        applyStimulus(2'b10, 2'b00, 0, 0);
        checkOutput("contIdleGap", {30'd0, comp_lock_res}, 2'b00);
        expectComp(1, 2'b10, 32'h11, 32'h21, 32'h31, 1);
        applyStimulus(2'b11, 2'b00, 0, 0);
        expectComp(0, 2'b10, 0, 0, 0, 1);
        applyStimulus(2'b11, 2'b00, 1, 0);
        applyStimulus(2'b01, 2'b00, 0, 0);
        checkOutput("contIdleGap2", {30'd0, comp_lock_res}, 2'b00);
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        applyStimulus(2'b01, 2'b00, 0, 0);
        expectComp(0, 2'b01, 0, 0, 0, 1);
        applyStimulus(2'b01, 2'b00, 1, 0);
        applyStimulus(2'b00, 2'b00, 0, 0);

        $display("[TB] channel independence");
        expectComp(1, 2'b10, 32'h11, 32'h21, 32'h31, 1);
        expectLoad(1, 2'b01, 32'h40, 1);
        applyStimulus(2'b10, 2'b01, 0, 0);
        A_addr[1] = 32'hDEAD; D_addr[1] = 32'hBEEF; B_addr[0] = 32'hCAFE;
        applyStimulus(2'b10, 2'b01, 0, 0);
        checkOutput("holdCompA", comp_A_addr, 32'h11);
        checkOutput("holdCompD", comp_D_addr, 32'h21);
        checkOutput("holdLoadB", load_B_addr, 32'h40);
        checkOutput("indepCompLock", {30'd0, comp_lock_res}, 2'b10);
        checkOutput("indepLoadLock", {30'd0, load_lock_res}, 2'b01);
        expectComp(0, 2'b10, 0, 0, 0, 1);
        expectLoad(0, 2'b01, 0, 1);
        applyStimulus(2'b10, 2'b01, 1, 1);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("indepCompRel", {30'd0, comp_lock_res}, 2'b00);
        checkOutput("indepLoadRel", {30'd0, load_lock_res}, 2'b00);
        A_addr[1] = 32'h11; D_addr[1] = 32'h21; B_addr[0] = 32'h40;

        $display("[TB] ignored events");
        applyStimulus(2'b00, 2'b00, 1, 1);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("idleDoneLock", {30'd0, comp_lock_res}, 2'b00);
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        applyStimulus(2'b01, 2'b00, 0, 0);
        applyStimulus(2'b00, 2'b00, 0, 0);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("dropHeld", {30'd0, comp_lock_res}, 2'b01);
        expectComp(0, 2'b01, 0, 0, 0, 1);
        applyStimulus(2'b00, 2'b00, 1, 0);
        checkOutput("dropFinishHold", {30'd0, comp_lock_res}, 2'b01);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("dropReleased", {30'd0, comp_lock_res}, 2'b00);

        $display("[TB] reset mid-busy");
        expectComp(1, 2'b10, 32'h11, 32'h21, 32'h31, 1);
        expectLoad(1, 2'b10, 32'h41, 1);
        applyStimulus(2'b10, 2'b10, 0, 0);
        applyStimulus(2'b10, 2'b10, 0, 0);
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncCompLock", {30'd0, comp_lock_res}, 2'b00);
        checkOutput("asyncLoadLock", {30'd0, load_lock_res}, 2'b00);
        checkOutput("asyncCompA", comp_A_addr, 0);
        checkOutput("asyncLoadB", load_B_addr, 0);
        comp_lock_req = 2'b00;
        load_lock_req = 2'b00;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        applyStimulus(2'b11, 2'b00, 0, 0);
        expectComp(0, 2'b01, 0, 0, 0, 1);
        applyStimulus(2'b11, 2'b00, 1, 0);
        applyStimulus(2'b10, 2'b00, 0, 0);
        expectComp(1, 2'b10, 32'h11, 32'h21, 32'h31, 1);
        applyStimulus(2'b10, 2'b00, 0, 0);
        expectComp(0, 2'b10, 0, 0, 0, 1);
        applyStimulus(2'b10, 2'b00, 1, 0);
        applyStimulus(2'b00, 2'b00, 0, 0);

`ifdef SYS_ARRAY_ARB_WATCHDOG_EN
        $display("[TB] watchdog expiry");
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        expectComp(0, 2'b01, 0, 0, 0, 9);
        applyStimulus(2'b01, 2'b00, 0, 0);
        repeat (7) applyStimulus(2'b01, 2'b00, 0, 0);
        checkOutput("wdBeforeExpiry", {31'd0, comp_timeout}, 0);
        checkOutput("wdHoldLock", {30'd0, comp_lock_res}, 2'b01);
        applyStimulus(2'b01, 2'b00, 0, 0);
        checkOutput("wdTimeoutSet", {31'd0, comp_timeout}, 1);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("wdReleased", {30'd0, comp_lock_res}, 2'b00);
        checkOutput("wdSticky", {31'd0, comp_timeout}, 1);
        checkOutput("wdLoadClear", {31'd0, load_timeout}, 0);
        resetDut();
        checkOutput("wdClearedByReset", {31'd0, comp_timeout}, 0);
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        expectComp(0, 2'b01, 0, 0, 0, 9);
        applyStimulus(2'b01, 2'b00, 0, 0);
        repeat (7) applyStimulus(2'b01, 2'b00, 0, 0);
        applyStimulus(2'b01, 2'b00, 1, 0);
        checkOutput("wdDoneAtExpiry", {31'd0, comp_timeout}, 0);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("wdDoneReleased", {30'd0, comp_lock_res}, 2'b00);
`else
        $display("[TB] long busy without watchdog");
        expectComp(1, 2'b01, 32'h10, 32'h20, 32'h30, 1);
        applyStimulus(2'b01, 2'b00, 0, 0);
        repeat (12) applyStimulus(2'b01, 2'b00, 0, 0);
        checkOutput("noWdHold", {30'd0, comp_lock_res}, 2'b01);
        checkOutput("noWdTimeout", {31'd0, comp_timeout}, 0);
        expectComp(0, 2'b01, 0, 0, 0, 1);
        applyStimulus(2'b01, 2'b00, 1, 0);
        applyStimulus(2'b00, 2'b00, 0, 0);
        checkOutput("noWdReleased", {30'd0, comp_lock_res}, 2'b00);
`endif

        repeat (2) @(negedge clock);
        checkOutput("compQueueEmpty", compQ.size(), 0);
        checkOutput("loadQueueEmpty", loadQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
